tmds_encode_hdmi: RTL
=====================

// Module: tmds_encode_hdmi
// PURPOSE
//  N-channel TMDS/HDMI symbol encoder; successor to the single-channel DVI encoder.
//  Adds the HDMI period types: TERC4 data-island coding, video and data-island
//    guard bands, and a clock enable.
//  Sits between the video timing/packet scheduler and the per-lane 10:1 serialisers.
//  One 10-bit symbol per channel per enabled cycle, fixed 3-cycle pipeline.
// PARAMETERS
//  N_CH    3  number of TMDS channels; channel k uses bit slices [k*W +: W]
//  W_DISP  6  width of each per-channel signed running-disparity counter
// PORTS
//  clk    in   1          pixel/symbol clock; sole clock
//  rst    in   1          asynchronous, active-high reset
//  en     in   1          clock enable; when low all state holds
//  mode   in   3          period type, shared by all channels:
//                         0 CTRL, 1 VIDEO, 2 TERC4, 3 VGUARD, 4 DGUARD; 5-7 treated as CTRL
//  c      in   2*N_CH     control bits {c1,c0} per channel (CTRL mode)
//  d      in   8*N_CH     pixel byte per channel (VIDEO mode)
//  terc4  in   4*N_CH     nibble per channel (TERC4 mode; DGUARD on channels k%3==0)
//  q      out  10*N_CH    encoded symbols; q[0] of each slice is transmitted first
//  disp   out  W_DISP*N_CH  per-channel running disparity, two's complement (debug/verification)
// BEHAVIOUR
//  Reset:
//   - q = 10'b1101010100 (CTRL 00) on every channel.
//   - disp = 0; all pipeline registers = 0; mode pipeline = CTRL.
//  Pipeline: inputs sampled on cycles with en=1; symbol appears on q exactly 3 enabled cycles later.
//   - en=0 freezes every register, including disparity.
//   - mode, c and terc4 are delayed alongside the data so all fields stay aligned.
//  Stage 1, transition minimisation (VIDEO):
//   - n1 = popcount(d).
//   - If n1>4, or n1==4 and d[0]==0: XNOR chain, q_m[8]=0.
//   - Otherwise: XOR chain, q_m[8]=1.
//   - q_m[0] = d[0] in both cases.
//  Stage 2, DC balance: N1/N0 = ones/zeros in q_m[7:0]; cnt is signed, counted in DVI units.
//   - If cnt==0 or N1==N0:
//       q = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}
//       cnt += q_m8 ? N1-N0 : N0-N1
//   - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
//       q = {1, q_m8, ~q_m[7:0]}
//       cnt += 2*q_m8 + N0-N1
//   - Else:
//       q = {0, q_m8, q_m[7:0]}
//       cnt += -2*(~q_m8) + N1-N0
//   - Any stage-2 symbol whose mode is not VIDEO forces cnt to 0 on that cycle.
//   - The override applies to the counter only, not the symbol mux.
//   - |cnt| never exceeds 2^(W_DISP-1)-1; for W_DISP=6 the bound holds by construction.
//  Stage 3, output mux by delayed mode:
//   - CTRL (per channel, by c): 00 -> 1101010100, 01 -> 0010101011,
//                               10 -> 0101010100, 11 -> 1010101011
//   - VIDEO: stage-2 symbol.
//   - TERC4 (nibble 0..F, bits q[9:0] MSB first):
//       0: 1010011100  1: 1001100011  2: 1011100100  3: 1011100010
//       4: 0101110001  5: 0100011110  6: 0110001110  7: 0100111100
//       8: 1011001100  9: 0100111001  A: 0110011100  B: 1011000111
//       C: 1010001110  D: 1001110001  E: 0101100011  F: 1011000011
//   - VGUARD: channel k%3==1 -> 0100110011; all others -> 1011001100.
//   - DGUARD: channel k%3==0 -> TERC4(terc4 nibble); all others -> 0100110011.
//  Channels are independent apart from the shared mode and en.
//  Mode changes take effect per symbol; there are no gaps and no warm-up cycles.
//  Reset asserted mid-stream: q and disp return to reset values immediately, asynchronously.
//   - After reset deasserts: CTRL 00 is output until the first sampled symbol arrives (3 enabled cycles).
//  disp is the stage-2 counter, updated in the same cycle as the stage-2 register.
// TESTING
//  1. Reset, then mode=CTRL with c=2'b01 on all channels -> q slices = 0010101011 from cycle 3; disp=0.
//  2. Reset, then mode=VIDEO, d=0x00 held -> q = 0100000000, 1111111111, 0100000000
//     with disp = -8, +2, -6.
//  3. Disparity check: 10k random VIDEO bytes -> q matches the bit-exact golden DVI model;
//     |disp| <= 10 throughout; disp -> 0 on the first CTRL symbol.
//  4. mode=TERC4 sweeping nibbles 0..F on ch0 -> q matches the table;
//     then DGUARD with terc4=0xC -> ch0 = 1010001110, ch1 = ch2 = 0100110011.
//  5. VGUARD for 2 cycles then VIDEO -> guard symbols 1011001100 / 0100110011 / 1011001100,
//     followed by video symbols starting from disparity 0.
//  6. Toggle en low for 5 cycles mid-VIDEO, and separately assert rst mid-stream
//     -> q and disp frozen while en=0; on rst, q = 1101010100 and disp = 0 asynchronously.

Source files
------------

// File: rtl/tmds_encode_hdmi.sv
// N-channel TMDS/HDMI symbol encoder: video DC-balanced coding, CTRL, TERC4 and guard bands.
// Three-stage pipeline (transition minimisation, DC balance, period mux) gated by en.
module tmds_encode_hdmi #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned W_DISP = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic [2*N_CH-1:0]        c,
  input  logic [8*N_CH-1:0]        d,
  input  logic [4*N_CH-1:0]        terc4,
  output logic [10*N_CH-1:0]       q,
  output logic [W_DISP*N_CH-1:0]   disp
);

  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_TERC4  = 3'd2;
  localparam logic [2:0] MODE_VGUARD = 3'd3;
  localparam logic [2:0] MODE_DGUARD = 3'd4;

  localparam logic [9:0] SYM_CTRL0   = 10'b1101010100;
  localparam logic [9:0] SYM_GUARD_A = 10'b1011001100;
  localparam logic [9:0] SYM_GUARD_B = 10'b0100110011;

  localparam logic signed [W_DISP-1:0] TWO  = W_DISP'(2);
  localparam logic signed [W_DISP-1:0] ZERO = '0;

  function automatic logic [8:0] transition_min(input logic [7:0] b);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] r;
    n1       = 4'($countones(b));
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !b[0]);
    r        = '0;
    r[0]     = b[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = use_xnor ? ~(r[i-1] ^ b[i]) : (r[i-1] ^ b[i]);
    end
    r[8] = ~use_xnor;
    return r;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] cc);
    case (cc)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] n);
    case (n)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000111;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  // Shared period/control fields travel with the data through stages 1 and 2
  logic [2:0]        s1_mode, s2_mode;
  logic [2*N_CH-1:0] s1_c, s2_c;
  logic [4*N_CH-1:0] s1_t, s2_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mode <= '0;
      s2_mode <= '0;
      s1_c    <= '0;
      s2_c    <= '0;
      s1_t    <= '0;
      s2_t    <= '0;
    end else if (en) begin
      s1_mode <= mode;
      s2_mode <= s1_mode;
      s1_c    <= c;
      s2_c    <= s1_c;
      s1_t    <= terc4;
      s2_t    <= s1_t;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int unsigned KM = k % 3;

    logic [8:0]               qm_c, s1_qm;
    logic [9:0]               sym_c, s2_sym, out_c, q_r;
    logic [3:0]               n1_c;
    logic signed [W_DISP-1:0] diff_c, cnt_nxt_c, cnt_r;

    assign qm_c = transition_min(d[k*8 +: 8]);

    // DC balance against the running disparity; diff_c = N1 - N0
    always_comb begin
      n1_c      = 4'($countones(s1_qm[7:0]));
      diff_c    = $signed(W_DISP'({n1_c, 1'b0})) - $signed(W_DISP'(8));
      sym_c     = {1'b0, s1_qm[8], s1_qm[7:0]};
      cnt_nxt_c = cnt_r - (s1_qm[8] ? ZERO : TWO) + diff_c;
      if ((cnt_r == ZERO) || (n1_c == 4'd4)) begin
        sym_c     = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
        cnt_nxt_c = s1_qm[8] ? (cnt_r + diff_c) : (cnt_r - diff_c);
      end else if ((!cnt_r[W_DISP-1] && (n1_c > 4'd4)) ||
                   (cnt_r[W_DISP-1] && (n1_c < 4'd4))) begin
        sym_c     = {1'b1, s1_qm[8], ~s1_qm[7:0]};
        cnt_nxt_c = cnt_r + (s1_qm[8] ? TWO : ZERO) - diff_c;
      end
      if (s1_mode != MODE_VIDEO) begin
        cnt_nxt_c = ZERO;
      end
    end

    always_comb begin
      out_c = ctrl_sym(s2_c[k*2 +: 2]);
      case (s2_mode)
        MODE_VIDEO:  out_c = s2_sym;
        MODE_TERC4:  out_c = terc4_sym(s2_t[k*4 +: 4]);
        MODE_VGUARD: out_c = (KM == 1) ? SYM_GUARD_B : SYM_GUARD_A;
        MODE_DGUARD: out_c = (KM == 0) ? terc4_sym(s2_t[k*4 +: 4]) : SYM_GUARD_B;
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_qm  <= '0;
        s2_sym <= '0;
        cnt_r  <= '0;
        q_r    <= SYM_CTRL0;
      end else if (en) begin
        s1_qm  <= qm_c;
        s2_sym <= sym_c;
        cnt_r  <= cnt_nxt_c;
        q_r    <= out_c;
      end
    end

    assign q[k*10 +: 10]          = q_r;
    assign disp[k*W_DISP +: W_DISP] = cnt_r;
  end

endmodule
